plab4_net_router_input_ctrl_tdm: RTL

Time-division-multiplexed input controller for one ring-router input port, parametrised over any number of security domains. It replaces the fixed two-domain, externally driven domain select with an internal round-robin slot scheduler. Each domain owns the port for a fixed number of cycles, with an optional guard band at the end of each slot. It sits between the input queue (dest/val/rdy) and the router's output-port arbiters (reqs/grants).

---
 rtl/plab4_net_router_input_ctrl_tdm.sv | 110 +++++++++++
 1 files changed

// File: rtl/plab4_net_router_input_ctrl_tdm.sv
// Time-division-multiplexed input controller: a round-robin slot scheduler hands the
// router input port to one security domain at a time. Optional guard band: PLAB4_NET_RIC_TDM_GUARD_EN.

module plab4_net_router_input_ctrl_tdm #(
    parameter int          p_router_id    = 0,
    parameter int          p_num_routers  = 8,
    parameter logic [2:0]  p_default_reqs = 3'b001,
    parameter int          p_num_domains  = 2,
    parameter int          p_slot_cycles  = 8,
    parameter int          p_guard_cycles = 1,
    localparam int         c_dest_nbits   = $clog2(p_num_routers),
    localparam int         c_dom_nbits    = $clog2(p_num_domains),
    localparam int         c_slot_nbits   = $clog2(p_slot_cycles)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_dest_nbits-1:0] dest,
    input  logic [c_dom_nbits-1:0]  in_domain,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [2:0]              reqs,
    input  logic [2:0]              grants,
    output logic [c_dom_nbits-1:0]  cur_domain,
    output logic                    slot_start
);

    localparam logic [c_slot_nbits-1:0] c_last_slot = c_slot_nbits'(p_slot_cycles - 1);
    localparam logic [c_dom_nbits-1:0]  c_last_dom  = c_dom_nbits'(p_num_domains - 1);
    localparam logic [c_dest_nbits-1:0] c_self_dest = c_dest_nbits'(p_router_id);

    // Parameter sanity: a bad configuration stops elaboration rather than misbehaving silently.
    if (p_num_domains < 2) begin : g_bad_domains
        $error("p_num_domains must be at least 2");
    end
    if (p_slot_cycles < 2) begin : g_bad_slot
        $error("p_slot_cycles must be at least 2");
    end
    if (p_guard_cycles >= p_slot_cycles) begin : g_bad_guard
        $error("p_guard_cycles must be smaller than p_slot_cycles");
    end

    logic [c_slot_nbits-1:0] slot_cnt_r;
    logic [c_dom_nbits-1:0]  cur_domain_r;
    logic [c_slot_nbits-1:0] slot_cnt_nxt_s;
    logic [c_dom_nbits-1:0]  cur_domain_nxt_s;
    logic                    slot_open_s;
    logic                    match_s;
    logic [2:0]              reqs_s;

    // Scheduler state register: the schedule restarts at domain 0, slot cycle 0 on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_r   <= {c_slot_nbits{1'b0}};
            cur_domain_r <= {c_dom_nbits{1'b0}};
        end else begin
            slot_cnt_r   <= slot_cnt_nxt_s;
            cur_domain_r <= cur_domain_nxt_s;
        end
    end

    // Next-state logic: the slot counter runs freely; ownership rotates at each slot wrap.
    always_comb begin
        slot_cnt_nxt_s   = slot_cnt_r + c_slot_nbits'(1);
        cur_domain_nxt_s = cur_domain_r;
        if (slot_cnt_r == c_last_slot) begin
            slot_cnt_nxt_s = {c_slot_nbits{1'b0}};
            if (cur_domain_r == c_last_dom) begin
                cur_domain_nxt_s = {c_dom_nbits{1'b0}};
            end else begin
                cur_domain_nxt_s = cur_domain_r + c_dom_nbits'(1);
            end
        end else begin
            cur_domain_nxt_s = cur_domain_r;
        end
    end

`ifdef PLAB4_NET_RIC_TDM_GUARD_EN
    localparam logic [c_slot_nbits:0] c_open_cycles = (c_slot_nbits + 1)'(p_slot_cycles - p_guard_cycles);

    // Guard band: the tail of each slot is closed so arbitration drains before ownership moves.
    always_comb begin
        slot_open_s = ({1'b0, slot_cnt_r} < c_open_cycles);
    end
`else
    // Without the guard band every cycle of the slot may transfer.
    always_comb begin
        slot_open_s = 1'b1;
    end
`endif

    // Output logic: requests only depend on scheduler state and the current head message.
    always_comb begin
        match_s = in_val && (in_domain == cur_domain_r) && slot_open_s;
        reqs_s  = 3'b000;
        if (match_s) begin
            if (dest == c_self_dest) begin
                reqs_s = 3'b010;
            end else begin
                reqs_s = p_default_reqs;
            end
        end else begin
            reqs_s = 3'b000;
        end
        reqs       = reqs_s;
        in_rdy     = (|(reqs_s & grants)) && !reset;
        cur_domain = cur_domain_r;
        slot_start = (slot_cnt_r == {c_slot_nbits{1'b0}});
    end

endmodule
